pc_call_stack_counter: RTL and testbench
========================================

// Module: pc_call_stack_counter
// PURPOSE
//  Parametrised program counter for the 8-bit CPU, successor to the 4-bit load/count PC.
//  Adds WIDTH-bit addressing, an internal DEPTH-entry return-address stack (CALL/RET)
//  and sticky stack error flags.
//  Sits between the control sequencer (lp/cp/ep/call/ret strobes) and the shared bus;
//  the bus driver is an explicit enable, not a tri-state.
// PARAMETERS
//  WIDTH  8  PC/address width in bits (>=2)
//  DEPTH  4  return-stack entries (>=1)
// PORTS
//  clk          in   1              single clock, all state updates on posedge
//  rst          in   1              reset; one clock, synchronous, active-high
//  lp           in   1              load PC from bits_in
//  cp           in   1              count (PC+1)
//  ep           in   1              enable PC onto bus
//  call         in   1              push PC, then load bits_in
//  ret          in   1              pop top of stack into PC
//  bits_in      in   WIDTH          bus value (jump/call target)
//  bits_out     out  WIDTH          pc when ep=1, else all zeros
//  bus_oe       out  1              =ep; bus mux select
//  pc           out  WIDTH          raw PC register
//  sp           out  $clog2(DEPTH+1) occupied stack entries
//  stack_full   out  1              sp==DEPTH
//  stack_empty  out  1              sp==0
//  err_ovf      out  1              sticky: call while full
//  err_unf      out  1              sticky: ret while empty
//  halted       out  1              wrap-halt status (0 without macro)
// BEHAVIOUR
//  - Reset: pc=0, sp=0, err_ovf=0, err_unf=0, halted=0; stack contents don't-care.
//  - Exactly one op per edge, priority: rst > lp > call > ret > cp > hold.
//  - Lower-priority strobes asserted in the same cycle are ignored, with no side effects.
//  - lp: pc<=bits_in next edge.
//  - cp: pc<=pc+1 mod 2^WIDTH; all-ones wraps to 0.
//  - call, not full: stack[sp]<=pc, sp<=sp+1, pc<=bits_in, all on the same edge.
//  - call, full: pc, sp and stack are unchanged; err_ovf<=1.
//  - ret, not empty: pc<=stack[sp-1], sp<=sp-1.
//  - ret, empty: pc and sp are unchanged; err_unf<=1.
//  - Sticky errors clear only on rst.
//  - Latency: every op is visible on pc one cycle after its strobe.
//  - bits_out and bus_oe are combinational from pc and ep, with zero latency.
//  - Flags and sp are registered and reflect post-edge state.
//  - Back-to-back call/ret on consecutive cycles is legal, with no bubble.
//  - call then ret returns the pushed pc exactly.
//  - rst mid-sequence (e.g. with sp=3) empties the stack on that edge; the pending op is discarded.
// CONFIGURATION
//  Macro PC_WRAP_HALT_EN:
//  - Defined: a cp from all-ones sets halted=1 and leaves pc at all-ones.
//  - While halted, cp is ignored.
//  - lp, call or ret clear halted and execute normally; rst also clears it.
//  - Undefined: pc wraps to 0 on cp; halted is tied 0.
// STRUCTURE
//  - Package pc_pkg:
//    - localparam op encodings OP_HOLD/OP_LOAD/OP_CALL/OP_RET/OP_INC (3 bits)
//    - function pc_op_sel(lp,call,ret,cp) implementing the priority above.
//  - Sub-module pc_return_stack (WIDTH, DEPTH):
//    - ports: clk, rst, push, pop, push_data, top_data, sp, full, empty.
//    - Register array plus sp counter; ignores push when full and pop when empty.
//  - Top level: op decode, PC register, error/halt flags, bus output gating.
// TESTING
//  1 rst=1 for 1 cycle with lp=1, bits_in=8'h5A -> pc=0, sp=0, stack_empty=1, errors 0.
//  2 lp=1, bits_in=8'hFE; then cp x3 -> pc FE,FF,00,01.
//    With PC_WRAP_HALT_EN: pc FE,FF,FF,FF and halted=1.
//  3 pc=8'h10; call to 20, 30, 40, 50 (DEPTH=4); ret x4 -> pc 40,30,20,10.
//    sp 4->0; stack_full high after 4th call.
//  4 stack full; call bits_in=8'h77 -> pc, sp unchanged, err_ovf=1.
//    Then ret x5 -> 5th ret sets err_unf=1, pc unchanged; both stay 1 until rst.
//  5 lp=1, call=1, cp=1 together, bits_in=8'h33 -> pc=33, sp unchanged (lp wins).
//    ret=1, cp=1 with sp=1 -> pop wins, no increment.
//  6 ep toggling 0/1 with pc=8'hA5 -> bits_out 00/A5, bus_oe follows ep same cycle.
//    Also sp=2 then rst -> sp=0, stack_empty=1 next edge.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program counter with return stack: op encodings
// and the strobe priority decoder used by the top level.
package pc_pkg;

   localparam logic [2:0] OP_HOLD = 3'd0;
   localparam logic [2:0] OP_LOAD = 3'd1;
   localparam logic [2:0] OP_CALL = 3'd2;
   localparam logic [2:0] OP_RET  = 3'd3;
   localparam logic [2:0] OP_INC  = 3'd4;

   // Picks exactly one operation per cycle: load > call > ret > count > hold.
   // Reset is handled ahead of this decode in the register processes.
   function automatic logic [2:0] pc_op_sel(input logic lp,
                                             input logic call,
                                             input logic ret,
                                             input logic cp);
      logic [2:0] op;
      if (lp) begin
         op = OP_LOAD;
      end else if (call) begin
         op = OP_CALL;
      end else if (ret) begin
         op = OP_RET;
      end else if (cp) begin
         op = OP_INC;
      end else begin
         op = OP_HOLD;
      end
      return op;
   endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Return-address stack: DEPTH registers plus an occupancy counter.
// A push while full and a pop while empty are ignored here; the caller
// raises the matching error flag.
module pc_return_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             push_data,
   output logic [WIDTH-1:0]             top_data,
   output logic [$clog2(DEPTH+1)-1:0]   sp,
   output logic                         full,
   output logic                         empty
);

   localparam int SPW = $clog2(DEPTH+1);

   logic [SPW-1:0]   sp_d, sp_q;
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [WIDTH-1:0] mem_q [DEPTH];

   assign sp    = sp_q;
   assign full  = (sp_q == SPW'(DEPTH));
   assign empty = (sp_q == {SPW{1'b0}});

   // Next occupancy and next contents; a push writes the slot at sp.
   always_comb begin
      sp_d  = sp_q;
      mem_d = mem_q;
      if (push && !full) begin
         sp_d = sp_q + {{(SPW-1){1'b0}}, 1'b1};
         for (int i = 0; i < DEPTH; i++) begin
            if (SPW'(i) == sp_q) begin
               mem_d[i] = push_data;
            end else begin
               mem_d[i] = mem_q[i];
            end
         end
      end else if (pop && !empty) begin
         sp_d = sp_q - {{(SPW-1){1'b0}}, 1'b1};
      end else begin
         sp_d = sp_q;
      end
   end

   // Top-of-stack read: the entry just below sp (zero when empty).
   always_comb begin
      top_data = {WIDTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         if (SPW'(i + 1) == sp_q) begin
            top_data = mem_q[i];
         end else begin
            top_data = top_data;
         end
      end
   end

   // Occupancy counter; reset empties the stack.
   always_ff @(posedge clk) begin
      if (rst) begin
         sp_q <= {SPW{1'b0}};
      end else begin
         sp_q <= sp_d;
      end
   end

   // Stack storage; contents are don't-care after reset so it is not cleared.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/pc_call_stack_counter.sv
// Program counter with load/count, CALL/RET through an internal return stack,
// sticky overflow/underflow flags and an enable-gated bus output.
// Optional feature macro: PC_WRAP_HALT_EN (count from all-ones halts instead
// of wrapping; halted is tied low when undefined).
module pc_call_stack_counter
   import pc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         lp,
   input  logic                         cp,
   input  logic                         ep,
   input  logic                         call,
   input  logic                         ret,
   input  logic [WIDTH-1:0]             bits_in,
   output logic [WIDTH-1:0]             bits_out,
   output logic                         bus_oe,
   output logic [WIDTH-1:0]             pc,
   output logic [$clog2(DEPTH+1)-1:0]   sp,
   output logic                         stack_full,
   output logic                         stack_empty,
   output logic                         err_ovf,
   output logic                         err_unf,
   output logic                         halted
);

   logic [2:0]       op;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] stk_top;
   logic [WIDTH-1:0] pc_d, pc_q;
   logic             err_ovf_d, err_ovf_q;
   logic             err_unf_d, err_unf_q;
   logic             halted_d, halted_q;

   pc_return_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_data (pc_q),
      .top_data  (stk_top),
      .sp        (sp),
      .full      (stack_full),
      .empty     (stack_empty)
   );

   // Decode the winning strobe and compute next PC, stack command and flags.
   always_comb begin
      op        = pc_op_sel(lp, call, ret, cp);
      pc_d      = pc_q;
      err_ovf_d = err_ovf_q;
      err_unf_d = err_unf_q;
      halted_d  = halted_q;
      push      = 1'b0;
      pop       = 1'b0;
      case (op)
         OP_LOAD: begin
            pc_d     = bits_in;
            halted_d = 1'b0;
         end
         OP_CALL: begin
            halted_d = 1'b0;
            if (stack_full) begin
               err_ovf_d = 1'b1;
            end else begin
               push = 1'b1;
               pc_d = bits_in;
            end
         end
         OP_RET: begin
            halted_d = 1'b0;
            if (stack_empty) begin
               err_unf_d = 1'b1;
            end else begin
               pop  = 1'b1;
               pc_d = stk_top;
            end
         end
         OP_INC: begin
`ifdef PC_WRAP_HALT_EN
            if (halted_q) begin
               pc_d = pc_q;
            end else if (pc_q == {WIDTH{1'b1}}) begin
               halted_d = 1'b1;
            end else begin
               pc_d = pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
            end
`else
            pc_d     = pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
            halted_d = 1'b0;
`endif
         end
         default: begin
            pc_d = pc_q;
         end
      endcase
   end

   // PC and status registers; reset overrides any op in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= {WIDTH{1'b0}};
         err_ovf_q <= 1'b0;
         err_unf_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         err_ovf_q <= err_ovf_d;
         err_unf_q <= err_unf_d;
         halted_q  <= halted_d;
      end
   end

   assign pc       = pc_q;
   assign err_ovf  = err_ovf_q;
   assign err_unf  = err_unf_q;
   assign halted   = halted_q;
   assign bus_oe   = ep;
   assign bits_out = ep ? pc_q : {WIDTH{1'b0}};

endmodule

// File: tb/tb_pc_call_stack_counter.sv
// Scoreboard bench for pc_call_stack_counter: a behavioural model predicts the
// post-edge state for every driven cycle, queues it, and compares on output.
module tb_pc_call_stack_counter;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int SPW   = $clog2(DEPTH+1);

   typedef struct packed {
      logic [WIDTH-1:0] pc;
      logic [SPW-1:0]   sp;
      logic             ovf;
      logic             unf;
      logic             halt;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst, lp, cp, ep, call, ret;
   logic [WIDTH-1:0] bits_in;
   logic [WIDTH-1:0] bits_out, pc;
   logic             bus_oe, stack_full, stack_empty, err_ovf, err_unf, halted;
   logic [SPW-1:0]   sp;

   int n_checks = 0;
   int n_pass   = 0;

   exp_t exp_q[$];

   // model state
   logic [WIDTH-1:0] m_pc;
   logic [WIDTH-1:0] m_stk [DEPTH];
   int               m_sp;
   logic             m_ovf, m_unf, m_halt;

   pc_call_stack_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .lp(lp), .cp(cp), .ep(ep), .call(call), .ret(ret),
      .bits_in(bits_in), .bits_out(bits_out), .bus_oe(bus_oe), .pc(pc), .sp(sp),
      .stack_full(stack_full), .stack_empty(stack_empty),
      .err_ovf(err_ovf), .err_unf(err_unf), .halted(halted)
   );

   // free-running clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   // apply one model step with the given strobes
   task automatic model(input logic r, input logic l, input logic c, input logic rt,
                        input logic inc, input logic [WIDTH-1:0] b);
      if (r) begin
         m_pc = '0; m_sp = 0; m_ovf = 1'b0; m_unf = 1'b0; m_halt = 1'b0;
      end else if (l) begin
         m_pc = b; m_halt = 1'b0;
      end else if (c) begin
         m_halt = 1'b0;
         if (m_sp == DEPTH) m_ovf = 1'b1;
         else begin m_stk[m_sp] = m_pc; m_sp++; m_pc = b; end
      end else if (rt) begin
         m_halt = 1'b0;
         if (m_sp == 0) m_unf = 1'b1;
         else begin m_sp--; m_pc = m_stk[m_sp]; end
      end else if (inc) begin
`ifdef PC_WRAP_HALT_EN
         if (!m_halt) begin
            if (m_pc == 8'hFF) m_halt = 1'b1;
            else m_pc = m_pc + 8'd1;
         end
`else
         m_pc = m_pc + 8'd1;
`endif
      end
   endtask

   // drive one cycle, queue the prediction, then compare after the edge
   task automatic step(input logic r, input logic l, input logic c, input logic rt,
                       input logic inc, input logic e, input logic [WIDTH-1:0] b);
      exp_t ex;
      @(negedge clk);
      rst = r; lp = l; call = c; ret = rt; cp = inc; ep = e; bits_in = b;
      model(r, l, c, rt, inc, b);
      ex.pc = m_pc; ex.sp = SPW'(m_sp); ex.ovf = m_ovf; ex.unf = m_unf; ex.halt = m_halt;
      exp_q.push_back(ex);
      @(posedge clk);
      #1;
      ex = exp_q.pop_front();
      check("pc", 32'(pc), 32'(ex.pc));
      check("sp", 32'(sp), 32'(ex.sp));
      check("full", 32'(stack_full), 32'(ex.sp == SPW'(DEPTH)));
      check("empty", 32'(stack_empty), 32'(ex.sp == '0));
      check("err_ovf", 32'(err_ovf), 32'(ex.ovf));
      check("err_unf", 32'(err_unf), 32'(ex.unf));
      check("halted", 32'(halted), 32'(ex.halt));
      check("bus_oe", 32'(bus_oe), 32'(e));
      check("bits_out", 32'(bits_out), e ? 32'(ex.pc) : 32'd0);
   endtask

   initial begin
      rst = 1'b0; lp = 1'b0; cp = 1'b0; ep = 1'b0; call = 1'b0; ret = 1'b0;
      bits_in = '0;
      m_pc = '0; m_sp = 0; m_ovf = 1'b0; m_unf = 1'b0; m_halt = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_stk[i] = '0;

      // 1: reset wins over a simultaneous load
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A);
      check("reset_pc", 32'(pc), 32'h0);

      // 2: load FE then count through the wrap point
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
`ifdef PC_WRAP_HALT_EN
      check("wrap_halt_pc", 32'(pc), 32'hFF);
`else
      check("wrap_pc", 32'(pc), 32'h01);
`endif

      // 3: nested calls to depth, then unwind
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h30);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h40);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h50);
      check("full_after_4", 32'(stack_full), 32'd1);

      // 4: overflow on full stack, then unwind past empty
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      check("unwound_pc", 32'(pc), 32'h10);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      check("sticky_both", 32'({err_ovf, err_unf}), 32'h3);

      // 5: priority between simultaneous strobes
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      check("pop_wins", 32'(pc), 32'h33);

      // 6: bus gating follows ep combinationally
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ep = i[0];
         #1;
         check("ep_bus_oe", 32'(bus_oe), 32'(i[0]));
         check("ep_bits_out", 32'(bits_out), i[0] ? 32'hA5 : 32'h0);
      end
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h60);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h70);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80);
      check("rst_empty", 32'({sp, stack_empty}), 32'h1);

      // random mix of strobes against the model
      for (int i = 0; i < 200; i++) begin
         step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0,
              8'($urandom_range(0, 255)));
      end

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
